sb_elastic_stage: RTL and testbench
===================================

SB_ELASTIC_STAGE -- requirements
Module: sb_elastic_stage

Interface
REQ-001 SHALL have parameter DW, default 256: payload width in bits; legal values are multiples of 8, minimum 8.
REQ-002 SHALL have parameter CW, default 32: width of the statistics counters.
REQ-003 SHALL have port clk, input, 1: single clock; all flops sample on its rising edge.
REQ-004 SHALL have port nreset, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1: synchronous buffer discard.
REQ-006 SHALL have port in_data, input, DW: upstream payload.
REQ-007 SHALL have port in_dest, input, 32: upstream destination.
REQ-008 SHALL have port in_last, input, 1: upstream end-of-packet marker.
REQ-009 SHALL have port in_valid, input, 1: upstream word offered.
REQ-010 SHALL have port in_ready, output, 1: stage can accept a word.
REQ-011 SHALL have ports out_data (DW), out_dest (32), out_last (1), out_valid (1), all outputs: downstream word, mirroring the upstream fields.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts.
REQ-013 SHALL have port word_cnt, output, CW: number of words transferred on the output side.
REQ-014 SHALL have port pkt_cnt, output, CW: number of output transfers with out_last=1.
REQ-015 SHALL have port drop_cnt, output, CW: number of words discarded by flush.
REQ-016 SHALL have port term_seen, output, 1: sticky flag indicating that an all-ones word has been output.

Function
REQ-017 SHALL implement a 2-entry FIFO holding {data, dest, last}; words leave in acceptance order with no reordering, duplication or field mixing.
REQ-018 SHALL count an input transfer when in_valid & in_ready, and an output transfer when out_valid & out_ready.
REQ-019 SHALL drive in_ready directly from a flop, equal to (occupancy < 2) as of the previous edge; in_ready SHALL have no combinational path from any input.
REQ-020 SHALL drive out_valid = (occupancy > 0), and out_data, out_dest and out_last from the head entry, all from flops.
REQ-021 SHALL make a word accepted at edge N visible on the output with out_valid=1 after edge N (1-cycle latency), provided the FIFO was empty.
REQ-022 SHALL allow a push and a pop in the same cycle when occupancy is 1; occupancy then stays 1 and the new word becomes the head.
REQ-023 SHALL hold in_ready=0 when occupancy is 2, including in a cycle where a pop occurs; in_ready returns to 1 at the next edge.
REQ-024 SHALL hold out_data, out_dest and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, when flush=1 at an edge: set occupancy to 0; add to drop_cnt the words held plus any word accepted in that cycle; ignore any pop in that cycle; and drive in_ready=1 after the edge.
REQ-026 SHALL increment word_cnt on each output transfer, and also increment pkt_cnt on each output transfer with out_last=1.
REQ-027 SHALL make all counters saturate at 2^CW-1; they SHALL NOT wrap.
REQ-028 SHALL set term_seen at the edge of an output transfer whose out_data is all ones; it is cleared only by reset, and flush does not clear it.
REQ-029 SHALL define behaviour for out_ready=1 while out_valid=0: no effect.

Reset
REQ-030 SHALL, while nreset=0, asynchronously force: occupancy 0, out_valid=0, in_ready=0, out_data/out_dest/out_last=0, all counters 0, term_seen=0.
REQ-031 SHALL drive in_ready=1 at the first clk edge after nreset deasserts.
REQ-032 SHALL, if reset asserts mid-packet, discard stored words without counting them in drop_cnt.

Verification
REQ-033 SHALL verify: single word data=0x01..01, dest=5, last=1, out_ready=1 -> out_valid high one cycle later with identical fields; word_cnt=1, pkt_cnt=1.
REQ-034 SHALL verify: out_ready=0 while 3 words are offered back-to-back -> 2 are accepted, in_ready=0 from the third cycle; after out_ready=1, the output order is 1,2,3 with no loss.
REQ-035 SHALL verify: continuous in_valid=1 and out_ready=1 for 100 words -> throughput 1 word/cycle after the first, word_cnt=100.
REQ-036 SHALL verify: 2 words buffered, then flush=1 together with an input handshake -> occupancy 0, drop_cnt=3, out_valid=0 the next cycle.
REQ-037 SHALL verify: output of an all-ones word -> term_seen=1 and it stays set through a subsequent flush; nreset pulse -> term_seen=0 and counters 0.
REQ-038 SHALL verify: CW=4, 20 output transfers with last=1 -> word_cnt=pkt_cnt=15, saturated.

Source files
------------

// File: rtl/sb_elastic_stage.sv
// sb_elastic_stage
//   Two-entry elastic buffer between a valid/ready producer and consumer,
//   with statistics counters and a sticky "all-ones word seen" flag.
//   in_ready and every downstream output come straight from flops, so the
//   stage fully breaks timing paths in both directions.
//
// Ports
//   clk, nreset                 clock, asynchronous active-low reset
//   flush                       synchronous discard of everything buffered
//   in_data/in_dest/in_last     upstream word, offered with in_valid
//   in_ready                    stage can take a word this cycle
//   out_data/out_dest/out_last  head-of-buffer word, offered with out_valid
//   out_ready                   downstream takes the head word
//   word_cnt, pkt_cnt           output transfers / output transfers with last
//   drop_cnt                    words thrown away by flush
//   term_seen                   sticky: an all-ones out_data was transferred
module sb_elastic_stage #(
  parameter int DW = 256,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          flush,
  input  logic [DW-1:0] in_data,
  input  logic [31:0]   in_dest,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic [31:0]   out_dest,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] word_cnt,
  output logic [CW-1:0] pkt_cnt,
  output logic [CW-1:0] drop_cnt,
  output logic          term_seen
);

  localparam int EW = DW + 33;

  // Entry layout: {data, dest, last}
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] tail_q, tail_d;
  logic [EW-1:0] in_entry;
  logic [1:0]    occ_q, occ_d;
  logic          push, pop;
  logic [1:0]    drop_inc;
  logic [CW+1:0] drop_sum;

  localparam logic [CW+1:0] DROP_MAX = {2'b00, {CW{1'b1}}};

  assign in_entry = {in_data, in_dest, in_last};
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  assign out_data = head_q[EW-1:33];
  assign out_dest = head_q[32:1];
  assign out_last = head_q[0];

  // Words lost to a flush: everything held plus a word accepted that cycle.
  assign drop_inc = occ_q + {1'b0, push};
  assign drop_sum = {2'b00, drop_cnt} + {{CW{1'b0}}, drop_inc};

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_d = in_entry;
            occ_d  = 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b11: head_d = in_entry;
            2'b10: begin
              tail_d = in_entry;
              occ_d  = 2'd2;
            end
            2'b01: occ_d = 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          // in_ready is low when full, so only a pop can happen here.
          if (pop) begin
            head_d = tail_q;
            occ_d  = 2'd1;
          end
        end
        default: occ_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      occ_q     <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      word_cnt  <= '0;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
      term_seen <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      out_valid <= (occ_d != 2'd0);
      in_ready  <= (occ_d != 2'd2);

      // A pop coinciding with flush is discarded, so it is not counted.
      if (pop && !flush) begin
        if (word_cnt != {CW{1'b1}}) word_cnt <= word_cnt + 1'b1;
        if (out_last && (pkt_cnt != {CW{1'b1}})) pkt_cnt <= pkt_cnt + 1'b1;
        if (&out_data) term_seen <= 1'b1;
      end

      if (flush) begin
        if (drop_sum > DROP_MAX) drop_cnt <= {CW{1'b1}};
        else                     drop_cnt <= drop_sum[CW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_sb_elastic_stage.sv
module tb_sb_elastic_stage;

  localparam int DW  = 256;
  localparam int CW  = 32;
  localparam int BDW = 8;
  localparam int BCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nreset, flush;
  logic [DW-1:0] in_data, out_data;
  logic [31:0]   in_dest, out_dest;
  logic          in_last, in_valid, in_ready;
  logic          out_last, out_valid, out_ready;
  logic [CW-1:0] word_cnt, pkt_cnt, drop_cnt;
  logic          term_seen;

  logic           b_flush;
  logic [BDW-1:0] b_in_data, b_out_data;
  logic [31:0]    b_in_dest, b_out_dest;
  logic           b_in_last, b_in_valid, b_in_ready;
  logic           b_out_last, b_out_valid, b_out_ready;
  logic [BCW-1:0] b_word_cnt, b_pkt_cnt, b_drop_cnt;
  logic           b_term_seen;

  int tests_run    = 0;
  int tests_failed = 0;

  sb_elastic_stage #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .nreset(nreset), .flush(flush),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_dest(out_dest), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .word_cnt(word_cnt), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
    .term_seen(term_seen)
  );

  sb_elastic_stage #(.DW(BDW), .CW(BCW)) dut_b (
    .clk(clk), .nreset(nreset), .flush(b_flush),
    .in_data(b_in_data), .in_dest(b_in_dest), .in_last(b_in_last),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_dest(b_out_dest), .out_last(b_out_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .word_cnt(b_word_cnt), .pkt_cnt(b_pkt_cnt), .drop_cnt(b_drop_cnt),
    .term_seen(b_term_seen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_last = 1'b0; in_dest = '0; in_data = '0;
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_dest !== '0 || out_last !== 1'b0) begin
      tests_failed++; $display("FAIL reset_outputs: got valid=%0b dest=%0h last=%0b want all 0", out_valid, out_dest, out_last);
    end
    tests_run++;
    if (word_cnt !== '0 || pkt_cnt !== '0 || drop_cnt !== '0 || term_seen !== 1'b0) begin
      tests_failed++; $display("FAIL reset_counters: got w=%0d p=%0d d=%0d t=%0b want 0", word_cnt, pkt_cnt, drop_cnt, term_seen);
    end
    @(negedge clk) nreset = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_before_edge: got %0b want 0", in_ready); end
    tick();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_first_edge: got %0b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (out_valid !== 1'b0 || word_cnt !== '0) begin
      tests_failed++; $display("FAIL idle_out_ready: got valid=%0b word_cnt=%0d want 0 0", out_valid, word_cnt);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_single();
    logic [DW-1:0] pat;
    do_reset();
    pat = {32{8'h01}};
    in_data = pat; in_dest = 32'd5; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_latency: got valid=%0b want 1", out_valid); end
    tests_run++;
    if (out_data !== pat || out_dest !== 32'd5 || out_last !== 1'b1) begin
      tests_failed++; $display("FAIL single_fields: got data=%0h dest=%0d last=%0b want data=%0h dest=5 last=1", out_data, out_dest, out_last, pat);
    end
    tick();
    tests_run++;
    if (word_cnt !== 32'd1 || pkt_cnt !== 32'd1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_counts: got w=%0d p=%0d valid=%0b want 1 1 0", word_cnt, pkt_cnt, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got[$];
    logic       took;
    do_reset();
    in_last = 1'b0; in_dest = 32'd7;
    in_valid = 1'b1; in_data = DW'(1);
    tick();
    in_data = DW'(2);
    tick();
    in_data = DW'(3);
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_ready: got %0b want 0", in_ready); end
    tick();
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== DW'(1)) begin
      tests_failed++; $display("FAIL bp_hold: got ready=%0b valid=%0b data=%0h want 0 1 1", in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      took = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(out_data[7:0]);
      tick();
      if (took) in_valid = 1'b0;
    end
    tests_run++;
    if (got.size() != 3) begin
      tests_failed++; $display("FAIL bp_count: got %0d words want 3", got.size());
    end else begin
      tests_run++;
      if (got[0] !== 8'd1 || got[1] !== 8'd2 || got[2] !== 8'd3) begin
        tests_failed++; $display("FAIL bp_order: got %0d,%0d,%0d want 1,2,3", got[0], got[1], got[2]);
      end
    end
    tests_run++;
    if (word_cnt !== 32'd3) begin tests_failed++; $display("FAIL bp_word_cnt: got %0d want 3", word_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_throughput();
    int sent, recv, gaps, bad, ready_low;
    do_reset();
    sent = 0; recv = 0; gaps = 0; bad = 0; ready_low = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 101; c++) begin
      in_valid = (sent < 100);
      in_data  = DW'(sent);
      if (!in_ready) ready_low++;
      if (c > 0 && !(out_valid && out_ready)) gaps++;
      if (out_valid && out_ready) begin
        if (out_data !== DW'(recv)) bad++;
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if (sent != 100 || recv != 100) begin tests_failed++; $display("FAIL tp_totals: got sent=%0d recv=%0d want 100 100", sent, recv); end
    tests_run++;
    if (gaps != 0 || ready_low != 0) begin tests_failed++; $display("FAIL tp_rate: got gaps=%0d ready_low=%0d want 0 0", gaps, ready_low); end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL tp_order: got %0d misordered want 0", bad); end
    tests_run++;
    if (word_cnt !== 32'd100 || pkt_cnt !== 32'd0) begin
      tests_failed++; $display("FAIL tp_counts: got w=%0d p=%0d want 100 0", word_cnt, pkt_cnt);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_data = DW'(10);
    tick();
    in_data = DW'(11);
    tick();
    flush = 1'b1; out_ready = 1'b1; in_data = DW'(99);
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_pre_ready: got %0b want 0", in_ready); end
    tick();
    flush = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (drop_cnt !== 32'd2 || out_valid !== 1'b0 || in_ready !== 1'b1 || word_cnt !== 32'd0) begin
      tests_failed++; $display("FAIL flush_held: got drop=%0d valid=%0b ready=%0b w=%0d want 2 0 1 0", drop_cnt, out_valid, in_ready, word_cnt);
    end
    flush = 1'b1; in_data = DW'(12);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (drop_cnt !== 32'd3 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL flush_handshake: got drop=%0d valid=%0b ready=%0b want 3 0 1", drop_cnt, out_valid, in_ready);
    end
    tick();
    in_valid = 1'b1; in_data = DW'(13);
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== DW'(13)) begin
      tests_failed++; $display("FAIL flush_recover: got valid=%0b data=%0h want 1 d", out_valid, out_data);
    end
  endtask

  task automatic test_term();
    logic [DW-1:0] near;
    do_reset();
    near = '1;
    near[0] = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = near;
    tick();
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (term_seen !== 1'b0) begin tests_failed++; $display("FAIL term_near: got %0b want 0", term_seen); end
    in_valid = 1'b1; in_data = '1;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (term_seen !== 1'b0) begin tests_failed++; $display("FAIL term_early: got %0b want 0", term_seen); end
    tick();
    tests_run++;
    if (term_seen !== 1'b1) begin tests_failed++; $display("FAIL term_set: got %0b want 1", term_seen); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (term_seen !== 1'b1) begin tests_failed++; $display("FAIL term_flush: got %0b want 1", term_seen); end
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(5);
    tick();
    tick();
    in_valid = 1'b0;
    nreset = 1'b0;
    #1;
    tests_run++;
    if (term_seen !== 1'b0 || word_cnt !== '0 || pkt_cnt !== '0 || drop_cnt !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL term_reset: got t=%0b w=%0d p=%0d d=%0d v=%0b r=%0b want all 0", term_seen, word_cnt, pkt_cnt, drop_cnt, out_valid, in_ready);
    end
    @(negedge clk) nreset = 1'b1;
    tick();
    tests_run++;
    if (drop_cnt !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_discard: got d=%0d v=%0b r=%0b want 0 0 1", drop_cnt, out_valid, in_ready);
    end
  endtask

  task automatic test_saturation();
    int bsent, brecv;
    do_reset();
    bsent = 0; brecv = 0;
    b_out_ready = 1'b1; b_in_last = 1'b1;
    for (int c = 0; c < 60; c++) begin
      b_in_valid = (bsent < 20);
      b_in_data  = BDW'(bsent);
      if (b_out_valid && b_out_ready) brecv++;
      if (b_in_valid && b_in_ready) bsent++;
      tick();
      if (brecv == 20) break;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    tests_run++;
    if (brecv != 20) begin tests_failed++; $display("FAIL sat_transfers: got %0d want 20", brecv); end
    tests_run++;
    if (b_word_cnt !== 4'd15 || b_pkt_cnt !== 4'd15) begin
      tests_failed++; $display("FAIL sat_counts: got w=%0d p=%0d want 15 15", b_word_cnt, b_pkt_cnt);
    end
  endtask

  initial begin
    nreset = 1'b0; flush = 1'b0;
    in_data = '0; in_dest = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    b_flush = 1'b0; b_in_data = '0; b_in_dest = '0; b_in_last = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_throughput();
    test_flush();
    test_term();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
